// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word and cache-line types
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache to physical memory arbiter, D-side priority
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     icache_pmem_read,
    input  lc3b_word icache_pmem_address,
    output logic     icache_pmem_resp,
    output lc3b_line icache_pmem_rdata,
    input  logic     dcache_pmem_read,
    input  logic     dcache_pmem_write,
    input  lc3b_word dcache_pmem_address,
    input  lc3b_line dcache_pmem_wdata,
    output logic     dcache_pmem_resp,
    output lc3b_line dcache_pmem_rdata,
    output logic     pmem_read,
    output logic     pmem_write,
    output lc3b_word pmem_address,
    output lc3b_line pmem_wdata,
    input  logic     pmem_resp,
    input  lc3b_line pmem_rdata
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_e;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_e state_q, state_d;
    logic       i_req, d_req, starve_force;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;
    assign starve_force = (starve_q == CW'(STARVE_LIMIT));
`else
    assign starve_force = 1'b0;
`endif

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && (!d_req || starve_force)) state_d = SERVE_I;
                else if (d_req)                        state_d = SERVE_D;
            end
            SERVE_I, SERVE_D: if (pmem_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_STARVE_GUARD_EN
    // Counts consecutive contested D wins; never exceeds the limit since I wins there.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && state_d == SERVE_I)      starve_d = '0;
        else if (state_q == IDLE && i_req && d_req)     starve_d = starve_q + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end

    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = dcache_pmem_address;
        pmem_wdata       = dcache_pmem_wdata;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        unique case (state_q)
            SERVE_I: begin
                pmem_read        = 1'b1;
                pmem_address     = icache_pmem_address;
                icache_pmem_resp = pmem_resp;
            end
            SERVE_D: begin
                pmem_write       = dcache_pmem_write;
                pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
                dcache_pmem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;
endmodule
